// File: rtl/zap_mem_arbiter_if.sv
// Bus bundle for zap_mem_arbiter: the D-side load/store port, the I-side
// fetch port and the single unified memory port.
//   D side : i_dram_rd_en/wr_en/addr/data/ben in; o_dram_data/o_dram_stall out
//   I side : i_iram_rd_en/addr in; o_iram_data/o_iram_stall out
//   Memory : o_mem_rd_en/wr_en/addr/data/ben out; i_mem_data/i_mem_stall in
// Modport slave is the arbiter's view; modport master is the view of the
// core and memory around it.
interface zap_mem_arbiter_if;
    logic        i_dram_rd_en;
    logic        i_dram_wr_en;
    logic [31:0] i_dram_addr;
    logic [31:0] i_dram_data;
    logic [3:0]  i_dram_ben;
    logic [31:0] o_dram_data;
    logic        o_dram_stall;
    logic        i_iram_rd_en;
    logic [31:0] i_iram_addr;
    logic [31:0] o_iram_data;
    logic        o_iram_stall;
    logic        o_mem_rd_en;
    logic        o_mem_wr_en;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_data;
    logic [3:0]  o_mem_ben;
    logic [31:0] i_mem_data;
    logic        i_mem_stall;

    modport slave (
        input  i_dram_rd_en, i_dram_wr_en, i_dram_addr, i_dram_data, i_dram_ben,
        output o_dram_data, o_dram_stall,
        input  i_iram_rd_en, i_iram_addr,
        output o_iram_data, o_iram_stall,
        output o_mem_rd_en, o_mem_wr_en, o_mem_addr, o_mem_data, o_mem_ben,
        input  i_mem_data, i_mem_stall
    );

    modport master (
        output i_dram_rd_en, i_dram_wr_en, i_dram_addr, i_dram_data, i_dram_ben,
        input  o_dram_data, o_dram_stall,
        output i_iram_rd_en, i_iram_addr,
        input  o_iram_data, o_iram_stall,
        input  o_mem_rd_en, o_mem_wr_en, o_mem_addr, o_mem_data, o_mem_ben,
        output i_mem_data, i_mem_stall
    );
endinterface

// File: rtl/zap_mem_arbiter.sv
// zap_mem_arbiter: shares one memory port between the I-side fetch port and
// the D-side load/store port. D has fixed priority; an I request that loses
// STARVE_LIMIT arbitrations in a row is forced through on the next one.
// A granted transaction is latched and runs to completion even if its
// requester withdraws.
// Ports:
//   i_clk   : clock, all state on the rising edge
//   i_reset : synchronous active-high reset
//   bus     : zap_mem_arbiter_if.slave (D side, I side, unified memory port)
module zap_mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    zap_mem_arbiter_if.slave  bus
);

    localparam int               CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, GNT_D, GNT_I} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             mem_rd_en_q, mem_rd_en_d;
    logic             mem_wr_en_q, mem_wr_en_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_data_q, mem_data_d;
    logic [3:0]       mem_ben_q, mem_ben_d;

    logic d_req;
    logic i_req;
    logic d_wins;

    assign d_req  = bus.i_dram_rd_en | bus.i_dram_wr_en;
    assign i_req  = bus.i_iram_rd_en;
    // D keeps priority until the I side has lost STARVE_LIMIT times in a row.
    assign d_wins = d_req & ((starve_cnt_q < LIMIT) | ~i_req);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            mem_rd_en_q  <= 1'b0;
            mem_wr_en_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_ben_q    <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            mem_rd_en_q  <= mem_rd_en_d;
            mem_wr_en_q  <= mem_wr_en_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_ben_q    <= mem_ben_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        mem_rd_en_d  = mem_rd_en_q;
        mem_wr_en_d  = mem_wr_en_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        mem_ben_d    = mem_ben_q;

        case (state_q)
            IDLE: begin
                if (d_wins) begin
                    state_d     = GNT_D;
                    mem_rd_en_d = bus.i_dram_rd_en;
                    mem_wr_en_d = bus.i_dram_wr_en;
                    mem_addr_d  = bus.i_dram_addr;
                    mem_data_d  = bus.i_dram_data;
                    mem_ben_d   = bus.i_dram_ben;
                    // When D wins against a pending I request the count is
                    // below LIMIT, so the increment cannot overshoot.
                    starve_cnt_d = i_req ? starve_cnt_q + CNT_W'(1) : '0;
                end else if (i_req) begin
                    state_d      = GNT_I;
                    mem_rd_en_d  = 1'b1;
                    mem_wr_en_d  = 1'b0;
                    mem_addr_d   = bus.i_iram_addr;
                    mem_data_d   = '0;
                    mem_ben_d    = 4'hF;
                    starve_cnt_d = '0;
                end else begin
                    starve_cnt_d = '0;
                end
            end
            GNT_D, GNT_I: begin
                // Completion returns to IDLE with the command cleared, which
                // produces the one-cycle bubble between transactions.
                if (!bus.i_mem_stall) begin
                    state_d     = IDLE;
                    mem_rd_en_d = 1'b0;
                    mem_wr_en_d = 1'b0;
                    mem_addr_d  = '0;
                    mem_data_d  = '0;
                    mem_ben_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.o_mem_rd_en = mem_rd_en_q;
    assign bus.o_mem_wr_en = mem_wr_en_q;
    assign bus.o_mem_addr  = mem_addr_q;
    assign bus.o_mem_data  = mem_data_q;
    assign bus.o_mem_ben   = mem_ben_q;

    assign bus.o_dram_data = bus.i_mem_data;
    assign bus.o_iram_data = bus.i_mem_data;

    // A requester that has withdrawn sees stall low, so a completion of its
    // abandoned transaction is silently dropped.
    assign bus.o_dram_stall = d_req & ~((state_q == GNT_D) & ~bus.i_mem_stall);
    assign bus.o_iram_stall = i_req & ~((state_q == GNT_I) & ~bus.i_mem_stall);

endmodule

// File: tb/tb_zap_mem_arbiter.sv
module tb_zap_mem_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    zap_mem_arbiter_if bus ();

    zap_mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: who currently owns the memory port (0 none, 1 D, 2 I),
    // the command that was captured for it, and how many arbitrations in a
    // row the I side has lost.
    int          owner;
    int          losses;
    logic        cmd_rd, cmd_wr;
    logic [31:0] cmd_addr, cmd_data;
    logic [3:0]  cmd_ben;
    logic        last_dstall, last_istall;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_cmd();
        cmd_rd = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_ben = '0;
    endtask

    // Compare all outputs against the model at the falling edge, advance the
    // model to what the next rising edge should produce, then return 1 time
    // unit after that edge so the caller can drive the next cycle's inputs.
    task automatic cycle();
        logic dq, iq, ms;
        logic [71:0] exp_v, obs_v;
        @(negedge clk);
        assert (!(bus.i_dram_rd_en && bus.i_dram_wr_en)) else begin
            n_err++;
            $error("FAIL illegal_rd_wr: observed rd=%b wr=%b", bus.i_dram_rd_en, bus.i_dram_wr_en);
        end
        dq = bus.i_dram_rd_en | bus.i_dram_wr_en;
        iq = bus.i_iram_rd_en;
        ms = bus.i_mem_stall;
        exp_v = {cmd_rd, cmd_wr, cmd_addr, cmd_data, cmd_ben,
                 dq & !(owner == 1 && !ms), iq & !(owner == 2 && !ms)};
        obs_v = {bus.o_mem_rd_en, bus.o_mem_wr_en, bus.o_mem_addr, bus.o_mem_data,
                 bus.o_mem_ben, bus.o_dram_stall, bus.o_iram_stall};
        check("cycle_outputs", obs_v, exp_v);
        check("read_data", 72'({bus.o_dram_data, bus.o_iram_data}),
              72'({bus.i_mem_data, bus.i_mem_data}));
        last_dstall = bus.o_dram_stall;
        last_istall = bus.o_iram_stall;
        if (rst) begin
            owner = 0; losses = 0; clear_cmd();
        end else if (owner != 0) begin
            if (!ms) begin owner = 0; clear_cmd(); end
        end else if (dq && (losses < STARVE_LIMIT || !iq)) begin
            owner = 1;
            cmd_rd = bus.i_dram_rd_en; cmd_wr = bus.i_dram_wr_en;
            cmd_addr = bus.i_dram_addr; cmd_data = bus.i_dram_data; cmd_ben = bus.i_dram_ben;
            losses = iq ? ((losses + 1 > STARVE_LIMIT) ? STARVE_LIMIT : losses + 1) : 0;
        end else if (iq) begin
            owner = 2;
            cmd_rd = 1'b1; cmd_wr = 1'b0; cmd_addr = bus.i_iram_addr; cmd_data = '0; cmd_ben = 4'hF;
            losses = 0;
        end else begin
            losses = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_d(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] ben);
        bus.i_dram_rd_en = rd; bus.i_dram_wr_en = wr;
        bus.i_dram_addr = addr; bus.i_dram_data = data; bus.i_dram_ben = ben;
    endtask

    logic d_act, i_act;

    initial begin
        n_cmp = 0; n_err = 0;
        owner = 0; losses = 0; clear_cmd();
        rst = 1'b1;
        drive_d(1'b0, 1'b0, '0, '0, '0);
        bus.i_iram_rd_en = 1'b0; bus.i_iram_addr = '0;
        bus.i_mem_stall = 1'b0; bus.i_mem_data = 32'h0;
        @(posedge clk); #1;
        cycle();
        rst = 1'b0;
        #1;
        check("reset_state", {bus.o_mem_rd_en, bus.o_mem_wr_en, bus.o_mem_addr,
                              bus.o_mem_data, bus.o_mem_ben, 2'b00}, 72'd0);
        cycle();

        // D read alone, 2 stall cycles
        drive_d(1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
        bus.i_mem_stall = 1'b1;
        #1; check("s1_req_rd_low", bus.o_mem_rd_en, 1'b0);
        check("s1_req_stall", bus.o_dram_stall, 1'b1);
        cycle();
        for (int k = 0; k < 2; k++) begin
            #1; check("s1_cmd_stalled", {bus.o_mem_rd_en, bus.o_mem_addr, bus.o_dram_stall},
                      {1'b1, 32'h100, 1'b1});
            cycle();
        end
        bus.i_mem_stall = 1'b0; bus.i_mem_data = 32'h1234_5678;
        #1; check("s1_done", {bus.o_mem_rd_en, bus.o_dram_stall, bus.o_dram_data},
                  {1'b1, 1'b0, 32'h1234_5678});
        cycle();
        drive_d(1'b0, 1'b0, '0, '0, '0);
        #1; check("s1_bubble", bus.o_mem_rd_en, 1'b0);
        cycle();

        // I fetches alone, 0-wait, back to back
        bus.i_iram_rd_en = 1'b1; bus.i_iram_addr = 32'h8000;
        cycle();
        for (int k = 0; k < 3; k++) begin
            #1; check("s2_fetch", {bus.o_mem_rd_en, bus.o_mem_addr, bus.o_mem_ben, bus.o_iram_stall},
                      {1'b1, 32'h8000 + 32'(4 * k), 4'hF, 1'b0});
            cycle();
            bus.i_iram_addr = 32'h8000 + 32'(4 * (k + 1));
            if (k == 2) bus.i_iram_rd_en = 1'b0;
            #1; check("s2_gap", {bus.o_mem_rd_en, bus.o_iram_stall}, {1'b0, (k != 2) ? 1'b1 : 1'b0});
            cycle();
        end

        // D and I together, D continuously: I forced through on the 5th arbitration
        drive_d(1'b1, 1'b0, 32'h200, 32'h0, 4'h3);
        bus.i_iram_rd_en = 1'b1; bus.i_iram_addr = 32'h9000;
        for (int k = 0; k < 6; k++) begin
            #1; check("s3_idle", {bus.o_mem_rd_en, bus.o_dram_stall, bus.o_iram_stall}, {1'b0, 1'b1, 1'b1});
            cycle();
            #1;
            if (k == 4)
                check("s3_i_forced", {bus.o_mem_addr, bus.o_mem_ben, bus.o_dram_stall, bus.o_iram_stall},
                      {32'h9000, 4'hF, 1'b1, 1'b0});
            else
                check("s3_d_grant", {bus.o_mem_addr, bus.o_mem_ben, bus.o_dram_stall, bus.o_iram_stall},
                      {32'h200, 4'h3, 1'b0, 1'b1});
            cycle();
        end
        drive_d(1'b0, 1'b0, '0, '0, '0);
        bus.i_iram_rd_en = 1'b0;
        cycle();

        // D write held through 3 stall cycles with operands going X
        drive_d(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'b0011);
        bus.i_mem_stall = 1'b1;
        cycle();
        bus.i_dram_addr = 'x; bus.i_dram_data = 'x; bus.i_dram_ben = 'x;
        for (int k = 0; k < 4; k++) begin
            bus.i_mem_stall = (k == 3) ? 1'b0 : 1'b1;
            #1; check("s4_latch", {bus.o_mem_wr_en, bus.o_mem_addr, bus.o_mem_data, bus.o_mem_ben, bus.o_dram_stall},
                      {1'b1, 32'h40, 32'hDEAD_BEEF, 4'b0011, (k == 3) ? 1'b0 : 1'b1});
            cycle();
        end
        drive_d(1'b0, 1'b0, '0, '0, '0);
        cycle();

        // I withdrawn while granted; D waits for completion plus the bubble
        bus.i_iram_rd_en = 1'b1; bus.i_iram_addr = 32'hA000; bus.i_mem_stall = 1'b1;
        cycle();
        cycle();
        bus.i_iram_rd_en = 1'b0;
        drive_d(1'b1, 1'b0, 32'h300, 32'h0, 4'hF);
        for (int k = 0; k < 3; k++) begin
            bus.i_mem_stall = (k == 2) ? 1'b0 : 1'b1;
            #1; check("s5_hold", {bus.o_mem_rd_en, bus.o_mem_addr, bus.o_iram_stall, bus.o_dram_stall},
                      {1'b1, 32'hA000, 1'b0, 1'b1});
            cycle();
        end
        #1; check("s5_bubble", {bus.o_mem_rd_en, bus.o_dram_stall}, {1'b0, 1'b1});
        cycle();
        #1; check("s5_d_grant", {bus.o_mem_rd_en, bus.o_mem_addr, bus.o_dram_stall}, {1'b1, 32'h300, 1'b0});
        cycle();
        drive_d(1'b0, 1'b0, '0, '0, '0);
        cycle();

        // Reset while D is granted and memory is stalled
        drive_d(1'b1, 1'b0, 32'h500, 32'h0, 4'hF);
        bus.i_mem_stall = 1'b1;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1; check("s6_reset_idle", {bus.o_mem_rd_en, bus.o_mem_wr_en, bus.o_dram_stall}, {1'b0, 1'b0, 1'b1});
        cycle();
        bus.i_mem_stall = 1'b0;
        #1; check("s6_regrant", {bus.o_mem_rd_en, bus.o_mem_addr, bus.o_dram_stall}, {1'b1, 32'h500, 1'b0});
        cycle();
        drive_d(1'b0, 1'b0, '0, '0, '0);
        cycle();

        // Randomized traffic against the model
        d_act = 1'b0; i_act = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (!d_act || !last_dstall) begin
                if ($urandom_range(0, 3) != 0) begin
                    d_act = 1'b1;
                    bus.i_dram_rd_en = 1'($urandom_range(0, 1));
                    bus.i_dram_wr_en = !bus.i_dram_rd_en;
                    bus.i_dram_addr = $urandom; bus.i_dram_data = $urandom;
                    bus.i_dram_ben = 4'($urandom_range(0, 15));
                end else begin
                    d_act = 1'b0;
                    drive_d(1'b0, 1'b0, '0, '0, '0);
                end
            end
            if (!i_act || !last_istall) begin
                i_act = ($urandom_range(0, 3) != 0);
                bus.i_iram_rd_en = i_act;
                bus.i_iram_addr = $urandom;
            end else if ($urandom_range(0, 19) == 0) begin
                i_act = 1'b0;
                bus.i_iram_rd_en = 1'b0;
            end
            bus.i_mem_stall = ($urandom_range(0, 2) == 0);
            bus.i_mem_data = $urandom;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
